// File: rtl/onboard_param_loader.sv
// ---------------------------------------------------------------------------
// onboard_param_loader
//
// Board-side front end for the egg-drop pipelined CPU. Synchronises and
// debounces the yes/ready push buttons, latches the 8-bit switch value into
// the eggs or floor operand register, holds the CPU in reset while operands
// are being set up, then steps the CPU with a clock-enable tick until the
// fetched instruction reads all-zero.
//
// Ports
//   clk_in      in   1  board clock
//   reset       in   1  asynchronous, active-high
//   btn_yes     in   1  raw button: latch sw_choose into the operand chosen by sw_id
//   btn_ready   in   1  raw button: operands complete, start the run
//   sw_id       in   1  operand select (0 = eggs, 1 = floor)
//   sw_choose   in   8  operand value
//   cpu_inst    in  32  instruction currently fetched by the CPU (0 = halt)
//   eggs        out 32  operand register, zero-extended
//   floor       out 32  operand register, zero-extended
//   cpu_rst     out  1  CPU reset, active-high
//   cpu_clk_en  out  1  one-cycle pulse per CPU step
//   state       out  2  0 SETUP, 1 LOAD, 2 RUN, 3 HALT
//   done        out  1  high in HALT
//   err         out  1  sticky: ready pressed while an operand was zero
// ---------------------------------------------------------------------------
module onboard_param_loader #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CPU_DIV         = 10000,
    parameter int LOAD_CYCLES     = 2
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        btn_yes,
    input  logic        btn_ready,
    input  logic        sw_id,
    input  logic [7:0]  sw_choose,
    input  logic [31:0] cpu_inst,
    output logic [31:0] eggs,
    output logic [31:0] floor,
    output logic        cpu_rst,
    output logic        cpu_clk_en,
    output logic [1:0]  state,
    output logic        done,
    output logic        err
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TK_W = (CPU_DIV > 1)         ? $clog2(CPU_DIV)         : 1;
    localparam int LD_W = (LOAD_CYCLES > 1)     ? $clog2(LOAD_CYCLES)     : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(CPU_DIV - 1);
    localparam logic [LD_W-1:0] LD_LAST = LD_W'(LOAD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SETUP = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Buttons: 2-FF synchroniser, debounce counter, rising-edge pulse.
    // Index 0 = yes, 1 = ready.
    // -----------------------------------------------------------------------
    logic [1:0] w_btn_raw;
    logic [1:0] w_press;

    assign w_btn_raw = {btn_ready, btn_yes};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic            r_meta;
            logic            r_sync;
            logic            r_level;
            logic            r_level_d;
            logic [DB_W-1:0] r_cnt;

            always_ff @(posedge clk_in or posedge reset) begin
                if (reset) begin
                    r_meta    <= 1'b0;
                    r_sync    <= 1'b0;
                    r_level   <= 1'b0;
                    r_level_d <= 1'b0;
                    r_cnt     <= '0;
                end else begin
                    r_meta    <= w_btn_raw[gi];
                    r_sync    <= r_meta;
                    r_level_d <= r_level;
                    // The counter only advances while the sample disagrees
                    // with the debounced level; any agreeing sample restarts it.
                    if (r_sync == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DB_LAST) begin
                        r_level <= r_sync;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            // Both terms are registers, so the pulse is glitch-free.
            assign w_press[gi] = r_level & ~r_level_d;
        end
    endgenerate

    logic w_yes_p;
    logic w_ready_p;

    assign w_yes_p   = w_press[0];
    assign w_ready_p = w_press[1];

    // -----------------------------------------------------------------------
    // Switch synchronisers (no debounce: only sampled on a yes pulse).
    // -----------------------------------------------------------------------
    logic       r_id_meta;
    logic       r_id_sync;
    logic [7:0] r_sw_meta;
    logic [7:0] r_sw_sync;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_id_meta <= 1'b0;
            r_id_sync <= 1'b0;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_id_meta <= sw_id;
            r_id_sync <= r_id_meta;
            r_sw_meta <= sw_choose;
            r_sw_sync <= r_sw_meta;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM. Every output is a register loaded from its _next value.
    // -----------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_next;
    logic [7:0]      r_eggs;
    logic [7:0]      w_eggs_next;
    logic [7:0]      r_floor;
    logic [7:0]      w_floor_next;
    logic            r_err;
    logic            w_err_next;
    logic [LD_W-1:0] r_load_cnt;
    logic [LD_W-1:0] w_load_cnt_next;
    logic [TK_W-1:0] r_tick_cnt;
    logic [TK_W-1:0] w_tick_cnt_next;
    logic            r_cpu_rst;
    logic            w_cpu_rst_next;
    logic            r_clk_en;
    logic            w_clk_en_next;
    logic            r_done;
    logic            w_done_next;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state    <= ST_SETUP;
            r_eggs     <= '0;
            r_floor    <= '0;
            r_err      <= 1'b0;
            r_load_cnt <= '0;
            r_tick_cnt <= '0;
            r_cpu_rst  <= 1'b1;
            r_clk_en   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_eggs     <= w_eggs_next;
            r_floor    <= w_floor_next;
            r_err      <= w_err_next;
            r_load_cnt <= w_load_cnt_next;
            r_tick_cnt <= w_tick_cnt_next;
            r_cpu_rst  <= w_cpu_rst_next;
            r_clk_en   <= w_clk_en_next;
            r_done     <= w_done_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_eggs_next     = r_eggs;
        w_floor_next    = r_floor;
        w_err_next      = r_err;
        w_load_cnt_next = r_load_cnt;
        w_tick_cnt_next = r_tick_cnt;
        w_cpu_rst_next  = 1'b1;
        w_clk_en_next   = 1'b0;
        w_done_next     = 1'b0;

        unique case (r_state)
            ST_SETUP: begin
                if (w_yes_p) begin
                    if (r_id_sync) begin
                        w_floor_next = r_sw_sync;
                    end else begin
                        w_eggs_next = r_sw_sync;
                    end
                    w_err_next = 1'b0;
                end
                // Checked against the current (pre-latch) operands, so a
                // simultaneous yes cannot rescue a zero operand this cycle.
                if (w_ready_p) begin
                    if (r_eggs == 8'd0 || r_floor == 8'd0) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_state_next    = ST_LOAD;
                        w_load_cnt_next = '0;
                    end
                end
            end

            ST_LOAD: begin
                // CPU stays in reset while its regfile captures eggs/floor.
                if (r_load_cnt == LD_LAST) begin
                    w_state_next    = ST_RUN;
                    w_cpu_rst_next  = 1'b0;
                    w_tick_cnt_next = '0;
                end else begin
                    w_load_cnt_next = r_load_cnt + 1'b1;
                end
            end

            ST_RUN: begin
                w_cpu_rst_next = 1'b0;
                if (r_tick_cnt == TK_LAST) begin
                    w_tick_cnt_next = '0;
                    // A zero fetch means the program has finished: skip the
                    // step so the CPU state is left exactly as it halted.
                    if (cpu_inst == 32'd0) begin
                        w_state_next = ST_HALT;
                        w_done_next  = 1'b1;
                    end else begin
                        w_clk_en_next = 1'b1;
                    end
                end else begin
                    w_tick_cnt_next = r_tick_cnt + 1'b1;
                end
            end

            ST_HALT: begin
                w_cpu_rst_next = 1'b0;
                w_done_next    = 1'b1;
                if (w_yes_p) begin
                    w_state_next   = ST_SETUP;
                    w_cpu_rst_next = 1'b1;
                    w_done_next    = 1'b0;
                end
            end

            default: begin
                w_state_next = ST_SETUP;
            end
        endcase
    end

    assign eggs       = {24'd0, r_eggs};
    assign floor      = {24'd0, r_floor};
    assign cpu_rst    = r_cpu_rst;
    assign cpu_clk_en = r_clk_en;
    assign state      = r_state;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_onboard_param_loader.sv
module tb_onboard_param_loader;

    logic        clk_in    = 1'b0;
    logic        reset     = 1'b1;
    logic        btn_yes   = 1'b0;
    logic        btn_ready = 1'b0;
    logic        sw_id     = 1'b0;
    logic [7:0]  sw_choose = 8'h00;
    logic [31:0] cpu_inst  = 32'h2008_0001;
    logic [31:0] eggs;
    logic [31:0] floor;
    logic        cpu_rst;
    logic        cpu_clk_en;
    logic [1:0]  state;
    logic        done;
    logic        err;

    onboard_param_loader #(
        .DEBOUNCE_CYCLES(4),
        .CPU_DIV        (3),
        .LOAD_CYCLES    (2)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .btn_yes   (btn_yes),
        .btn_ready (btn_ready),
        .sw_id     (sw_id),
        .sw_choose (sw_choose),
        .cpu_inst  (cpu_inst),
        .eggs      (eggs),
        .floor     (floor),
        .cpu_rst   (cpu_rst),
        .cpu_clk_en(cpu_clk_en),
        .state     (state),
        .done      (done),
        .err       (err)
    );

    always #5 clk_in = ~clk_in;

    int n_err    = 0;
    int n_checks = 0;

    typedef struct {
        bit          is_ready;
        bit          id;
        logic [7:0]  val;
        logic [31:0] e_eggs;
        logic [31:0] e_floor;
        logic        e_err;
        logic [1:0]  e_state;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic press_yes(input bit id, input logic [7:0] v);
        sw_id     = id;
        sw_choose = v;
        cyc(3);
        btn_yes = 1'b1;
        cyc(10);
        btn_yes = 1'b0;
        cyc(10);
    endtask

    task automatic press_ready();
        btn_ready = 1'b1;
        cyc(10);
        btn_ready = 1'b0;
        cyc(10);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_eggs"},  eggs,              32'd0);
        check({tag, "_floor"}, floor,             32'd0);
        check({tag, "_rst"},   32'(cpu_rst),      32'd1);
        check({tag, "_clken"}, 32'(cpu_clk_en),   32'd0);
        check({tag, "_state"}, 32'(state),        32'd0);
        check({tag, "_done"},  32'(done),         32'd0);
        check({tag, "_err"},   32'(err),          32'd0);
    endtask

    // Press ready from SETUP and follow LOAD into RUN; returns on the first
    // negedge at which state reads RUN.
    task automatic start_run(input string tag);
        int t_run;
        int n_load;
        int n_load_rst;
        int n_early;
        logic rst_at_run;
        t_run      = -1;
        n_load     = 0;
        n_load_rst = 0;
        n_early    = 0;
        rst_at_run = 1'b1;
        btn_ready  = 1'b1;
        for (int i = 0; i < 40 && t_run < 0; i++) begin
            @(negedge clk_in);
            if (i == 12) btn_ready = 1'b0;
            if (cpu_clk_en) n_early++;
            if (state == 2'd1) begin
                n_load++;
                if (cpu_rst) n_load_rst++;
            end
            if (state == 2'd2) begin
                t_run      = i;
                rst_at_run = cpu_rst;
            end
        end
        btn_ready = 1'b0;
        check({tag, "_load_len"},   32'(n_load),     32'd2);
        check({tag, "_load_rst"},   32'(n_load_rst), 32'd2);
        check({tag, "_run_seen"},   32'(t_run >= 0), 32'd1);
        check({tag, "_run_rst"},    32'(rst_at_run), 32'd0);
        check({tag, "_no_early"},   32'(n_early),    32'd0);
        $display("txn %s: run entered after %0d cycles", tag, t_run);
    endtask

    task automatic wait_pulse(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk_in);
            if (cpu_clk_en) got = 1'b1;
        end
        check({tag, "_pulse_seen"}, 32'(got), 32'd1);
    endtask

    initial begin
        int n_latch;
        int n_bad;
        int t_halt;
        int n_pulse;
        logic [31:0] prev_eggs;

        vecs[0] = '{is_ready: 1'b0, id: 1'b0, val: 8'h02, e_eggs: 32'd2, e_floor: 32'd0,   e_err: 1'b0, e_state: 2'd0};
        vecs[1] = '{is_ready: 1'b1, id: 1'b0, val: 8'h00, e_eggs: 32'd2, e_floor: 32'd0,   e_err: 1'b1, e_state: 2'd0};
        vecs[2] = '{is_ready: 1'b0, id: 1'b1, val: 8'h00, e_eggs: 32'd2, e_floor: 32'd0,   e_err: 1'b0, e_state: 2'd0};
        vecs[3] = '{is_ready: 1'b1, id: 1'b0, val: 8'h00, e_eggs: 32'd2, e_floor: 32'd0,   e_err: 1'b1, e_state: 2'd0};
        vecs[4] = '{is_ready: 1'b0, id: 1'b1, val: 8'h64, e_eggs: 32'd2, e_floor: 32'd100, e_err: 1'b0, e_state: 2'd0};

        // Reset values at power-up.
        cyc(3);
        check_reset_vals("por");
        $display("txn reset: state=%0d cpu_rst=%0d", state, cpu_rst);
        reset = 1'b0;
        cyc(2);

        // Bounce filtering: 2-cycle toggles for 20 cycles, then held high.
        sw_id     = 1'b0;
        sw_choose = 8'h05;
        cyc(3);
        n_latch   = 0;
        prev_eggs = eggs;
        for (int i = 0; i < 30; i++) begin
            btn_yes = (i < 20) ? ((i / 2) % 2 == 0) : 1'b1;
            @(negedge clk_in);
            if (eggs !== prev_eggs) n_latch++;
            prev_eggs = eggs;
            if (i == 19) check("bounce_no_latch", eggs, 32'd0);
        end
        btn_yes = 1'b0;
        cyc(10);
        check("bounce_latches", 32'(n_latch), 32'd1);
        check("bounce_eggs",    eggs,         32'd5);
        check("bounce_floor",   floor,        32'd0);
        $display("txn bounce: latches=%0d eggs=%h", n_latch, eggs);

        // Table of SETUP operations.
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].is_ready) press_ready();
            else                  press_yes(vecs[v].id, vecs[v].val);
            check($sformatf("vec%0d_eggs", v),  eggs,          vecs[v].e_eggs);
            check($sformatf("vec%0d_floor", v), floor,         vecs[v].e_floor);
            check($sformatf("vec%0d_err", v),   32'(err),      32'(vecs[v].e_err));
            check($sformatf("vec%0d_state", v), 32'(state),    32'(vecs[v].e_state));
            check($sformatf("vec%0d_rst", v),   32'(cpu_rst),  32'd1);
            $display("txn vec%0d: ready=%0d id=%0d val=%h -> eggs=%h floor=%h err=%0d state=%0d",
                     v, vecs[v].is_ready, vecs[v].id, vecs[v].val, eggs, floor, err, state);
        end

        // Start the run and check the tick cadence.
        start_run("run1");
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk_in);
            check($sformatf("tick_c%0d", j), 32'(cpu_clk_en), 32'((j % 3) == 0));
        end
        $display("txn ticks: cadence checked over 9 cycles");

        // Buttons are ignored while running.
        press_yes(1'b0, 8'hAA);
        press_ready();
        check("run_eggs_frozen",  eggs,       32'd2);
        check("run_floor_frozen", floor,      32'd100);
        check("run_state",        32'(state), 32'd2);
        $display("txn run_buttons: eggs=%h floor=%h state=%0d", eggs, floor, state);

        // Halt: zero fetch suppresses the next tick.
        wait_pulse("pre_halt");
        cpu_inst = 32'd0;
        t_halt   = -1;
        n_pulse  = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_in);
            if (cpu_clk_en) n_pulse++;
            if (state == 2'd3 && t_halt < 0) t_halt = k;
        end
        check("halt_latency", 32'(t_halt),  32'd3);
        check("halt_pulses",  32'(n_pulse), 32'd0);
        check("halt_done",    32'(done),    32'd1);
        check("halt_rst",     32'(cpu_rst), 32'd0);
        $display("txn halt: state=%0d done=%0d after %0d cycles", state, done, t_halt);

        press_ready();
        check("halt_ready_ignored", 32'(state), 32'd3);

        // Return from HALT.
        press_yes(1'b0, 8'hAA);
        check("ret_state", 32'(state),   32'd0);
        check("ret_rst",   32'(cpu_rst), 32'd1);
        check("ret_done",  32'(done),    32'd0);
        check("ret_eggs",  eggs,         32'd2);
        check("ret_floor", floor,        32'd100);
        $display("txn return: state=%0d eggs=%h floor=%h", state, eggs, floor);

        // Reset in the middle of a run.
        cpu_inst = 32'h2008_0001;
        start_run("run2");
        wait_pulse("pre_reset");
        cyc(2);
        #1 reset = 1'b1;
        #1 check_reset_vals("midrun");
        $display("txn midrun_reset: state=%0d cpu_clk_en=%0d", state, cpu_clk_en);
        cyc(3);
        reset = 1'b0;
        n_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (cpu_clk_en || state != 2'd0) n_bad++;
        end
        check("post_reset_idle", 32'(n_bad), 32'd0);

        press_yes(1'b0, 8'h03);
        press_yes(1'b1, 8'h04);
        check("reload_eggs",  eggs,  32'd3);
        check("reload_floor", floor, 32'd4);
        start_run("run3");
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk_in);
            check($sformatf("first_tick_c%0d", j), 32'(cpu_clk_en), 32'(j == 3));
        end
        $display("txn rerun: first tick checked");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Overall time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "time limit reached");
    end

endmodule
